hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether PC and IF/ID advance, hold or flush, and whether the ID/EX register loads the decoded instruction or a bubble (zeros, via its rst input).
- Detects load-use hazards, resolves taken-branch flushes, and sequences a fixed-latency multiply/divide unit with a busy counter and state machine.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/md_busy_timer.sv | 80 ++++++++
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types and constants for the 5-stage MIPS pipeline sequencing logic.
//   - state_e    : mult/div sequencer state (RUN, MD_BUSY)
//   - ZERO_REG   : architectural $zero, which never carries a real dependency
//   - MD_LAT_DEF : default mult/div latency in cycles
//   - CNT_W_DEF  : default mult/div down-counter width
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] ZERO_REG   = 5'd0;
    localparam int         MD_LAT_DEF = 32;
    localparam int         CNT_W_DEF  = 6;

endpackage

// File: rtl/md_busy_timer.sv
// ---------------------------------------------------------------------------
// md_busy_timer
//   Fixed-latency mult/div sequencer. A start pulse loads the down-counter
//   with MD_LAT-1 and enters MD_BUSY; the counter then ticks down to zero,
//   and the zero cycle is the done cycle. A start in the done cycle reloads
//   the counter, so back-to-back operations keep busy high.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset; aborts any sequence
//   start   in   one-cycle start pulse (only legal in RUN or the done cycle)
//   busy    out  high exactly while in MD_BUSY (forced low during rst)
//   done    out  one-cycle pulse in the final busy cycle (cnt==0)
//   cnt_nz  out  MD_BUSY with counter not yet zero (result not ready)
// ---------------------------------------------------------------------------
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic cnt_nz
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LAT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        cnt_nz  = 1'b0;
        case (state_q)
            RUN: begin
                if (start) begin
                    cnt_d   = LOAD_VAL;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // Outputs are masked while rst is high so an aborted
                // sequence never shows a done pulse.
                busy   = ~rst;
                cnt_nz = (cnt_q != '0);
                done   = (cnt_q == '0) & ~rst;
                if (start) begin
                    cnt_d   = LOAD_VAL;
                    state_d = MD_BUSY;
                end else if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it
//   decides whether PC and IF/ID advance, hold or flush, and whether ID/EX
//   takes the decoded instruction or a bubble. Detects load-use hazards,
//   applies taken-branch flushes and sequences the mult/div unit.
//
//   Optional feature: define HAZARD_STALL_CNT_EN to build a saturating
//   32-bit stall-cycle counter; otherwise stall_cycles is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs, id_rt        source fields of the ID instruction
//   id_uses_rs/rt       ID instruction actually reads rs / rt
//   id_is_muldiv        ID instruction is mult/multu/div/divu
//   id_reads_hilo       ID instruction is mfhi/mflo
//   ex_mem_read         EX instruction is a load
//   ex_rt               load destination held in ID/EX
//   ex_branch_taken     branch/jump in EX resolved taken
//   pc_we, ifid_we      PC / IF/ID load enables
//   ifid_flush          IF/ID loads zeros next edge
//   idex_bubble         ID/EX loads zeros next edge
//   md_start            one-cycle start pulse to the mult/div unit
//   md_busy, md_done    mult/div in progress / final busy cycle
//   stall_cycles        performance count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_muldiv,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    logic lu, mdh, stall;
    logic md_cnt_nz;

    // Load-use: the loaded value is not forwardable until after MEM, so a
    // consumer directly behind the load waits one cycle. $zero never
    // carries a dependency.
    assign lu = ex_mem_read & (ex_rt != ZERO_REG) &
                ((id_uses_rs & (id_rs == ex_rt)) |
                 (id_uses_rt & (id_rt == ex_rt)));

    // HI/LO hazard: a new mult/div or an mfhi/mflo waits while the unit is
    // still counting; the done cycle (counter zero) lets it through.
    assign mdh   = md_cnt_nz & (id_is_muldiv | id_reads_hilo);
    assign stall = lu | mdh;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // ID holds a wrong-path instruction: its hazards are irrelevant.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            md_start    = id_is_muldiv;
        end
    end

    md_busy_timer #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .busy   (md_busy),
        .done   (md_done),
        .cnt_nz (md_cnt_nz)
    );

`ifdef HAZARD_STALL_CNT_EN
    logic        stall_evt;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A branch-overridden hazard is not a real stall.
    assign stall_evt = stall & ~ex_branch_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
